rr_mux4: RTL and testbench

RR_MUX4 -- requirements
Module: rr_mux4

---
 rtl/rr_mux_pkg.sv | 10 +
 rtl/rr_arbiter4.sv | 47 ++++
 rtl/rr_mux4.sv | 92 +++++++++
 tb/tb_rr_mux4.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/rr_mux_pkg.sv
// Shared constants and output-stage state encoding for the 4-channel round-robin mux.
package rr_mux_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;
endpackage

// File: rtl/rr_arbiter4.sv
// 4-way arbiter: round-robin from last_grant+1, or fixed priority (ch0 highest)
// when RR_MUX4_FIXED_PRIO_EN is defined. Purely combinational; enable=0 suppresses the grant.
module rr_arbiter4
  import rr_mux_pkg::*;
(
  input  logic [NUM_CH-1:0] requests,
  input  logic [SEL_W-1:0]  last_grant,
  input  logic              enable,
  output logic              grant_valid,
  output logic [SEL_W-1:0]  grant_idx
);

`ifdef RR_MUX4_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (requests[i]) begin
        grant_valid = 1'b1;
        grant_idx   = SEL_W'(i);
      end
    end
    if (!enable) grant_valid = 1'b0;
  end
`else
  logic [SEL_W-1:0] cand;

  // Walk from farthest to nearest so the channel right after last_grant wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      cand = last_grant + SEL_W'(i);
      if (requests[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
    if (!enable) grant_valid = 1'b0;
  end
`endif

endmodule

// File: rtl/rr_mux4.sv
// 4-to-1 valid/ready serializer with a single output register (1-cycle latency).
// Arbitration policy selected by RR_MUX4_FIXED_PRIO_EN (default: round-robin).
module rr_mux4
  import rr_mux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_in_0,
  input  logic [WIDTH-1:0] d_in_1,
  input  logic [WIDTH-1:0] d_in_2,
  input  logic [WIDTH-1:0] d_in_3,
  input  logic             v_in_0,
  input  logic             v_in_1,
  input  logic             v_in_2,
  input  logic             v_in_3,
  output logic             r_in_0,
  output logic             r_in_1,
  output logic             r_in_2,
  output logic             r_in_3,
  output logic [WIDTH-1:0] d_out,
  output logic [SEL_W-1:0] d_sel,
  output logic             d_valid,
  input  logic             d_ready
);

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    last_grant;
  logic                load_en;
  logic                grant_valid;
  logic [SEL_W-1:0]    grant_idx;
  logic [NUM_CH-1:0]   requests;
  logic [NUM_CH-1:0]   ready_vec;
  logic [WIDTH-1:0]    sel_dat;

  assign requests = {v_in_3, v_in_2, v_in_1, v_in_0};
  assign load_en  = (state_q == EMPTY) || d_ready;

  // Reset also gates the grant so no channel sees an accept while rst is high.
  rr_arbiter4 u_arb (
    .requests    (requests),
    .last_grant  (last_grant),
    .enable      (load_en & ~rst),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_comb begin
    ready_vec = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      ready_vec[k] = grant_valid && (grant_idx == SEL_W'(k));
    end
  end

  assign {r_in_3, r_in_2, r_in_1, r_in_0} = ready_vec;

  always_comb begin
    sel_dat = d_in_0;
    case (grant_idx)
      2'd1:    sel_dat = d_in_1;
      2'd2:    sel_dat = d_in_2;
      2'd3:    sel_dat = d_in_3;
      default: sel_dat = d_in_0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (load_en) state_d = grant_valid ? FULL : EMPTY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  assign d_valid = (state_q == FULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_out      <= '0;
      d_sel      <= '0;
      last_grant <= SEL_W'(NUM_CH - 1);
    end else if (load_en && grant_valid) begin
      d_out      <= sel_dat;
      d_sel      <= grant_idx;
      last_grant <= grant_idx;
    end
  end

endmodule

// File: tb/tb_rr_mux4.sv
// Directed bench for rr_mux4: hand-computed expectations, immediate assertions at each check.
module tb_rr_mux4;
  localparam int W = 8;

  logic         clk, rst;
  logic [W-1:0] d_in_0, d_in_1, d_in_2, d_in_3;
  logic         v_in_0, v_in_1, v_in_2, v_in_3;
  logic         r_in_0, r_in_1, r_in_2, r_in_3;
  logic [W-1:0] d_out;
  logic [1:0]   d_sel;
  logic         d_valid, d_ready;

  int vectors = 0;
  int errors  = 0;

  rr_mux4 #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .d_in_0(d_in_0), .d_in_1(d_in_1), .d_in_2(d_in_2), .d_in_3(d_in_3),
    .v_in_0(v_in_0), .v_in_1(v_in_1), .v_in_2(v_in_2), .v_in_3(v_in_3),
    .r_in_0(r_in_0), .r_in_1(r_in_1), .r_in_2(r_in_2), .r_in_3(r_in_3),
    .d_out(d_out), .d_sel(d_sel), .d_valid(d_valid), .d_ready(d_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] rdy();
    return {r_in_3, r_in_2, r_in_1, r_in_0};
  endfunction

  task automatic set_v(input logic [3:0] v);
    {v_in_3, v_in_2, v_in_1, v_in_0} = v;
  endtask

  // Downstream 1-to-4 demux: only the lane named by d_sel carries the word.
  function automatic logic [4*W-1:0] demux(input logic dv, input logic [1:0] sel, input logic [W-1:0] dat);
    logic [4*W-1:0] bus;
    bus = '0;
    if (dv) bus[sel*W +: W] = dat;
    return bus;
  endfunction

  initial begin
    logic [1:0]     exp_k;
    logic [W-1:0]   exp_d;
    logic [4*W-1:0] exp_bus;

    rst = 1'b1; d_ready = 1'b0;
    d_in_0 = 8'hA0; d_in_1 = 8'hA1; d_in_2 = 8'hA2; d_in_3 = 8'hA3;
    set_v(4'h0);

    @(negedge clk);
    chk("rst_valid", 32'(d_valid), 32'h0);
    chk("rst_dout", 32'(d_out), 32'h0);
    chk("rst_dsel", 32'(d_sel), 32'h0);
    set_v(4'hF); d_ready = 1'b1;
    #1 chk("rst_rdy_gated", 32'(rdy()), 32'h0);

    // Rotating stream, all channels valid.
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
`ifdef RR_MUX4_FIXED_PRIO_EN
      exp_k = 2'd0;
`else
      exp_k = 2'(i % 4);
`endif
      exp_d   = 8'hA0 + W'(exp_k);
      exp_bus = '0;
      exp_bus[exp_k*W +: W] = exp_d;
      #1 chk("stream_rdy", 32'(rdy()), 32'(4'b0001 << exp_k));
      @(posedge clk); #1;
      chk("stream_valid", 32'(d_valid), 32'h1);
      chk("stream_dsel", 32'(d_sel), 32'(exp_k));
      chk("stream_dout", 32'(d_out), 32'(exp_d));
      chk("stream_demux", demux(d_valid, d_sel, d_out), exp_bus);
      @(negedge clk);
    end

`ifdef RR_MUX4_FIXED_PRIO_EN
    set_v(4'b1001);
    for (int i = 0; i < 3; i++) begin
      #1 chk("fixed_rdy", 32'(rdy()), 32'h1);
      @(posedge clk); #1;
      chk("fixed_dsel", 32'(d_sel), 32'h0);
      @(negedge clk);
    end
`endif

    // Backpressure hold on channel 2.
    set_v(4'b0100); d_in_2 = 8'h5C;
    #1 chk("bp_load_rdy", 32'(rdy()), 32'b0100);
    @(posedge clk); #1;
    chk("bp_load_dout", 32'(d_out), 32'h5C);
    @(negedge clk); d_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_hold_rdy", 32'(rdy()), 32'h0);
      @(posedge clk); #1;
      chk("bp_hold_valid", 32'(d_valid), 32'h1);
      chk("bp_hold_dsel", 32'(d_sel), 32'h2);
      chk("bp_hold_dout", 32'(d_out), 32'h5C);
      @(negedge clk);
    end
    d_ready = 1'b1; d_in_2 = 8'h5D;
    #1 chk("bp_release_rdy", 32'(rdy()), 32'b0100);
    @(posedge clk); #1;
    chk("bp_release_dout", 32'(d_out), 32'h5D);
    @(negedge clk);

    // Wrap-around search.
    set_v(4'b1000); d_in_3 = 8'h33;
    #1 chk("wrap_g3_rdy", 32'(rdy()), 32'b1000);
    @(posedge clk); #1 chk("wrap_g3_dsel", 32'(d_sel), 32'h3);
    @(negedge clk); set_v(4'b0010); d_in_1 = 8'h11;
    #1 chk("wrap_g1_rdy", 32'(rdy()), 32'b0010);
    @(posedge clk); #1 chk("wrap_g1_dout", 32'(d_out), 32'h11);
    @(negedge clk); set_v(4'b0011); d_in_0 = 8'h0F;
    #1 chk("wrap_g0_rdy", 32'(rdy()), 32'b0001);
    @(posedge clk); #1;
    chk("wrap_g0_dsel", 32'(d_sel), 32'h0);
    chk("wrap_g0_dout", 32'(d_out), 32'h0F);

    // Drain to EMPTY, idle, then check last_grant survived.
    @(negedge clk); set_v(4'h0);
    #1 chk("drain_rdy", 32'(rdy()), 32'h0);
    @(posedge clk); #1 chk("drain_valid", 32'(d_valid), 32'h0);
    @(posedge clk); #1 chk("idle_valid", 32'(d_valid), 32'h0);
    @(negedge clk); set_v(4'b0110); d_in_2 = 8'h22;
    #1 chk("idle_resume_rdy", 32'(rdy()), 32'b0010);
    @(posedge clk); #1;
    chk("idle_resume_dsel", 32'(d_sel), 32'h1);
    chk("idle_resume_dout", 32'(d_out), 32'h11);

    // Async reset mid-stream while FULL.
    @(negedge clk); set_v(4'hF);
    d_in_0 = 8'hA0; d_in_1 = 8'hA1; d_in_2 = 8'hA2; d_in_3 = 8'hA3;
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(d_valid), 32'h0);
    chk("arst_dout", 32'(d_out), 32'h0);
    chk("arst_dsel", 32'(d_sel), 32'h0);
    chk("arst_rdy", 32'(rdy()), 32'h0);
    @(negedge clk); rst = 1'b0;
    #1 chk("post_rst_rdy", 32'(rdy()), 32'b0001);
    @(posedge clk); #1;
    chk("post_rst_dsel", 32'(d_sel), 32'h0);
    chk("post_rst_dout", 32'(d_out), 32'hA0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
